// File: rtl/antares_div_pkg.sv
// Shared types and constants for the EX-stage divider.
// Optional build macro: ANTARES_DIV_ZERO_FAST_EN.
package antares_div_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    localparam int          DIV_ITERATIONS    = 32;
    localparam logic [31:0] DIV_ZERO_QUOTIENT = 32'hFFFF_FFFF;

    function automatic logic [31:0] div_neg(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

endpackage

// File: rtl/antares_div_step.sv
// One restoring-division iteration: shift in a dividend bit,
// subtract the divisor if it fits.
module antares_div_step (
    input  logic [31:0] rem_i,
    input  logic        bit_i,
    input  logic [31:0] dvs_i,
    output logic [31:0] rem_o,
    output logic        q_o
);

    logic [33:0] diff;

    // 34 bits so diff[33] is a clean borrow flag
    assign diff  = {1'b0, rem_i, bit_i} - {2'b00, dvs_i};
    assign q_o   = ~diff[33];
    assign rem_o = q_o ? diff[31:0] : {rem_i[30:0], bit_i};

endmodule

// File: rtl/antares_ex_divider.sv
// Multi-cycle 32-bit DIV/DIVU unit for the EX stage.
// ANTARES_DIV_ZERO_FAST_EN: zero divisor skips the iteration.
module antares_ex_divider
    import antares_div_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_divs,
    input  logic        op_divu,
    input  logic [31:0] ex_data_rs,
    input  logic [31:0] ex_data_rt,
    input  logic        ex_flush,
    output logic        div_stall,
    output logic        div_done,
    output logic [31:0] div_quotient,
    output logic [31:0] div_remainder
);

    div_state_e  state_q;
    logic [4:0]  cnt_q;
    logic [31:0] dvd_q;
    logic [31:0] dvs_q;
    logic [31:0] rem_q;
    logic        negq_q;
    logic        negr_q;
    logic        dz_q;
    logic [31:0] quo_q;
    logic [31:0] rmd_q;

    logic        req;
    logic        start;
    logic [31:0] rs_mag;
    logic [31:0] rt_mag;
    logic [31:0] step_rem;
    logic        step_q;
    logic [31:0] q_raw;
    logic [31:0] q_fix;
    logic [31:0] r_fix;

    assign req   = op_divs | op_divu;
    assign start = req & ~ex_flush & (state_q == DIV_IDLE);

    assign rs_mag = (op_divs & ex_data_rs[31]) ?
                    div_neg(ex_data_rs) : ex_data_rs;
    assign rt_mag = (op_divs & ex_data_rt[31]) ?
                    div_neg(ex_data_rt) : ex_data_rt;

    antares_div_step u_step (
        .rem_i (rem_q),
        .bit_i (dvd_q[31]),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

    // The dividend register shifts left and fills with quotient bits
    assign q_raw = {dvd_q[30:0], step_q};
    assign q_fix = dz_q   ? DIV_ZERO_QUOTIENT :
                   negq_q ? div_neg(q_raw) : q_raw;
    assign r_fix = negr_q ? div_neg(step_rem) : step_rem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DIV_IDLE;
            cnt_q   <= 5'd0;
            dvd_q   <= 32'd0;
            dvs_q   <= 32'd0;
            rem_q   <= 32'd0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            dz_q    <= 1'b0;
            quo_q   <= 32'd0;
            rmd_q   <= 32'd0;
        end else begin
            unique case (state_q)
                DIV_IDLE: begin
                    if (start) begin
                        dvd_q   <= rs_mag;
                        dvs_q   <= rt_mag;
                        rem_q   <= 32'd0;
                        negq_q  <= op_divs &
                                   (ex_data_rs[31] ^ ex_data_rt[31]);
                        negr_q  <= op_divs & ex_data_rs[31];
                        dz_q    <= (ex_data_rt == 32'd0);
                        cnt_q   <= 5'(DIV_ITERATIONS - 1);
`ifdef ANTARES_DIV_ZERO_FAST_EN
                        if (ex_data_rt == 32'd0) begin
                            quo_q   <= DIV_ZERO_QUOTIENT;
                            rmd_q   <= ex_data_rs;
                            state_q <= DIV_DONE;
                        end else begin
                            state_q <= DIV_RUN;
                        end
`else
                        state_q <= DIV_RUN;
`endif
                    end
                end
                DIV_RUN: begin
                    if (ex_flush) begin
                        state_q <= DIV_IDLE;
                    end else begin
                        rem_q <= step_rem;
                        dvd_q <= q_raw;
                        if (cnt_q == 5'd0) begin
                            quo_q   <= q_fix;
                            rmd_q   <= r_fix;
                            state_q <= DIV_DONE;
                        end else begin
                            cnt_q <= cnt_q - 5'd1;
                        end
                    end
                end
                DIV_DONE: begin
                    state_q <= DIV_IDLE;
                end
                default: begin
                    state_q <= DIV_IDLE;
                end
            endcase
        end
    end

    // rst_n gating keeps the handshake quiet while reset is held
    assign div_stall = rst_n & (start | (state_q == DIV_RUN));
    assign div_done  = rst_n & (state_q == DIV_DONE) & ~ex_flush;

    assign div_quotient  = quo_q;
    assign div_remainder = rmd_q;

endmodule
